// File: rtl/apb_arb_defs_pkg.sv
// apb_arb_defs: shared types for the two-requester APB arbiter.
//   state_t : arbiter FSM encoding (IDLE=0, SETUP=1, ACCESS=2)
//   idx_t   : requester index, IW bits wide
package apb_arb_defs;
    localparam int IW = 1;
    typedef logic [IW-1:0] idx_t;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;
endpackage

// File: rtl/apb_arb_timer.sv
// apb_arb_timer: access-phase watchdog counter for the APB arbiter.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the count
//   enable       : count one more cycle
//   expired      : count has reached TIMEOUT_CYCLES (always 0 when TIMEOUT_CYCLES is 0)
module apb_arb_timer #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TW = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TW-1:0] count;
    always_ff @(posedge clock)
        if (reset || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    assign expired = (TIMEOUT_CYCLES != 0) && (count == TW'(TIMEOUT_CYCLES));
endmodule

// File: rtl/apb_arbiter_2m1s.sv
// apb_arbiter_2m1s: round-robin arbiter sharing one APB completer between two requesters.
//   clock, reset            : system clock, synchronous active-high reset
//   m0_* / m1_* (in)        : requester APB address/control/data
//   m0_* / m1_* (out)       : pready/prdata/pslverr returned to each requester
//   out_* (out)             : completer address/control/data driven by the arbiter
//   out_pready/prdata/pslverr (in) : completer response
module apb_arbiter_2m1s
    import apb_arb_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TW = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [2:0]  m0_pprot,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,
    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [2:0]  m1_pprot,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [2:0]  out_pprot,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);
    state_t state;
    idx_t   owner;
    idx_t   rr;
    logic   expired, done, timeout, active, q0, q1;
    // requests are recognised by psel alone; penable carries no information here
    logic   unused;
    assign unused = m0_penable ^ m1_penable;

    apb_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TW(TW)) timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == SETUP),
        .enable  (state == ACCESS && !out_pready),
        .expired (expired)
    );

    // reset gates completion so an aborted transfer never reports pready
    assign done    = (state == ACCESS) && !reset && (out_pready || expired);
    assign timeout = done && !out_pready;
    assign active  = state != IDLE;
    assign q0      = done && owner == 1'b0;
    assign q1      = done && owner == 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            rr    <= '0;
        end else begin
            case (state)
                IDLE:
                    if (m0_psel || m1_psel) begin
                        owner <= (m0_psel && m1_psel) ? rr : idx_t'(m1_psel);
                        state <= SETUP;
                    end
                SETUP: state <= ACCESS;
                ACCESS:
                    if (done) begin
                        rr    <= ~owner;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_psel    = active;
    assign out_penable = state == ACCESS;
    assign out_paddr   = !active ? '0 : owner[0] ? m1_paddr  : m0_paddr;
    assign out_pwrite  = !active ? '0 : owner[0] ? m1_pwrite : m0_pwrite;
    assign out_pprot   = !active ? '0 : owner[0] ? m1_pprot  : m0_pprot;
    assign out_pwdata  = !active ? '0 : owner[0] ? m1_pwdata : m0_pwdata;
    assign out_pstrb   = !active ? '0 : owner[0] ? m1_pstrb  : m0_pstrb;

    assign m0_pready  = q0;
    assign m1_pready  = q1;
    assign m0_prdata  = (q0 && !timeout) ? out_prdata : '0;
    assign m1_prdata  = (q1 && !timeout) ? out_prdata : '0;
    assign m0_pslverr = q0 && (out_pslverr || timeout);
    assign m1_pslverr = q1 && (out_pslverr || timeout);
endmodule

// File: tb/tb_apb_arbiter_2m1s.sv
// tb_apb_arbiter_2m1s: self-checking bench for apb_arbiter_2m1s built with a 4-cycle timeout.
module tb_apb_arbiter_2m1s;
    localparam int TO = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0][31:0]  paddr, pwdata;
    logic [1:0]        psel, penable, pwrite;
    logic [1:0][2:0]   pprot;
    logic [1:0][3:0]   pstrb;
    logic [1:0]        rdy, err;
    logic [1:0][31:0]  rdat;
    logic [31:0]       out_paddr, out_pwdata, out_prdata;
    logic              out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [2:0]        out_pprot;
    logic [3:0]        out_pstrb;

    int checks = 0;
    int errors = 0;
    int rr_m = 0;
    int own;

    apb_arbiter_2m1s #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
        .clock(clock), .reset(reset),
        .m0_paddr(paddr[0]), .m0_psel(psel[0]), .m0_penable(penable[0]), .m0_pwrite(pwrite[0]),
        .m0_pprot(pprot[0]), .m0_pwdata(pwdata[0]), .m0_pstrb(pstrb[0]),
        .m0_pready(rdy[0]), .m0_prdata(rdat[0]), .m0_pslverr(err[0]),
        .m1_paddr(paddr[1]), .m1_psel(psel[1]), .m1_penable(penable[1]), .m1_pwrite(pwrite[1]),
        .m1_pprot(pprot[1]), .m1_pwdata(pwdata[1]), .m1_pstrb(pstrb[1]),
        .m1_pready(rdy[1]), .m1_prdata(rdat[1]), .m1_pslverr(err[1]),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pwrite(out_pwrite), .out_pprot(out_pprot), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // every arbiter output must be 0 (IDLE, nothing completing)
    task automatic chk_quiet(input string tag);
        chk({tag, "_psel"}, 32'(out_psel), 0);
        chk({tag, "_penable"}, 32'(out_penable), 0);
        chk({tag, "_paddr"}, out_paddr, 0);
        chk({tag, "_pwdata"}, out_pwdata, 0);
        chk({tag, "_ctl"}, 32'({out_pwrite, out_pprot, out_pstrb}), 0);
        chk({tag, "_pready"}, 32'(rdy), 0);
        chk({tag, "_pslverr"}, 32'(err), 0);
        chk({tag, "_prdata0"}, rdat[0], 0);
        chk({tag, "_prdata1"}, rdat[1], 0);
    endtask

    task automatic new_req(input int i);
        psel[i]    = 1'b1;
        penable[i] = 1'($urandom);
        paddr[i]   = $urandom;
        pwdata[i]  = $urandom;
        pwrite[i]  = 1'($urandom);
        pprot[i]   = 3'($urandom);
        pstrb[i]   = 4'($urandom);
    endtask

    // Called in an IDLE cycle with requests driven. Walks one whole transfer:
    // IDLE, SETUP, w wait cycles (or TO for a timeout), completion cycle.
    task automatic serve(input int w, input logic [31:0] rd, input bit se, input bit to, output int o);
        o = (psel[0] && psel[1]) ? rr_m : (psel[1] ? 1 : 0);
        @(negedge clock);
        chk_quiet("idle");
        next_cycle();
        @(negedge clock);
        chk("setup_psel", 32'(out_psel), 1);
        chk("setup_penable", 32'(out_penable), 0);
        chk("setup_paddr", out_paddr, paddr[o]);
        chk("setup_pwdata", out_pwdata, pwdata[o]);
        chk("setup_ctl", 32'({out_pwrite, out_pprot, out_pstrb}), 32'({pwrite[o], pprot[o], pstrb[o]}));
        chk("setup_pready", 32'(rdy), 0);
        next_cycle();
        for (int i = 0; i < (to ? TO : w); i++) begin
            out_pready  = 1'b0;
            out_prdata  = $urandom;
            out_pslverr = 1'($urandom);
            @(negedge clock);
            chk("wait_penable", 32'(out_penable), 1);
            chk("wait_paddr", out_paddr, paddr[o]);
            chk("wait_resp", 32'({rdy, err}), 0);
            chk("wait_prdata", rdat[0] | rdat[1], 0);
            next_cycle();
        end
        out_pready  = !to;
        out_prdata  = to ? ($urandom | 32'h1) : rd;
        out_pslverr = to ? 1'b0 : se;
        @(negedge clock);
        chk("done_penable", 32'(out_penable), 1);
        chk("done_pready", 32'(rdy), 32'(1) << o);
        chk("done_pslverr", 32'(err), (se || to) ? 32'(1) << o : 0);
        chk("done_prdata_owner", rdat[o], to ? 0 : rd);
        chk("done_prdata_other", rdat[1-o], 0);
        next_cycle();
        rr_m        = 1 - o;
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;
        psel[o]     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pprot = '0; pstrb = '0;
        out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
        repeat (3) next_cycle();
        @(negedge clock);
        chk_quiet("in_reset");
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk_quiet("after_reset");
        next_cycle();

        // m0 alone reads with two wait states
        new_req(0);
        paddr[0] = 32'h10002004;
        pwrite[0] = 1'b0;
        serve(2, 32'h0000A5A5, 1'b0, 1'b0, own);

        // m1 alone, zero-wait, hands priority back to m0
        new_req(1);
        serve(0, $urandom, 1'b0, 1'b0, own);

        // simultaneous writes: m0 then m1
        new_req(0);
        new_req(1);
        paddr[0] = 32'h10002000; pwrite[0] = 1'b1;
        paddr[1] = 32'h10002000; pwrite[1] = 1'b1;
        serve(1, $urandom, 1'b0, 1'b0, own);
        serve(0, $urandom, 1'b0, 1'b0, own);

        // continuous requests from both alternate
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 2; i++) if (!psel[i]) new_req(i);
            serve(int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'b0, own);
        end
        psel = '0;

        // hung completer on m0
        new_req(0);
        serve(0, 0, 1'b0, 1'b1, own);

        // error forwarded to m1 only
        new_req(1);
        serve(1, $urandom, 1'b1, 1'b0, own);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) if (!psel[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (psel == 2'b00) begin
                @(negedge clock);
                chk_quiet("rand_idle");
                next_cycle();
            end else begin
                serve(int'($urandom_range(0, 3)), $urandom, 1'($urandom), $urandom_range(0, 7) == 0, own);
            end
        end
        psel = '0;

        // reset during ACCESS: m0 finishes first so rr favours m1, then both request
        new_req(0);
        serve(0, $urandom, 1'b0, 1'b0, own);
        new_req(0);
        new_req(1);
        next_cycle();
        @(negedge clock);
        chk("rst_setup_paddr", out_paddr, paddr[1]);
        next_cycle();
        out_pready = 1'b1;
        out_prdata = 32'hDEAD_BEEF;
        out_pslverr = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_cycle_pready", 32'(rdy), 0);
        chk("rst_cycle_prdata", rdat[0] | rdat[1], 0);
        next_cycle();
        reset = 1'b0;
        out_pready = 1'b0;
        out_prdata = '0;
        out_pslverr = 1'b0;
        rr_m = 0;
        serve(0, $urandom, 1'b0, 1'b0, own);
        serve(2, $urandom, 1'b0, 1'b0, own);
        @(negedge clock);
        chk_quiet("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
